// File: rtl/remote_pos_packer_if.sv
// remote_pos_packer_if
// AXI-Stream TX bundle between the position packer and the network port.
//   o_tdata  : beat payload (slots or the iteration's marker count)
//   o_tvalid : beat valid
//   i_tready : downstream ready
//   o_tlast  : set on the marker beat only
//   o_tdest  : destination FPGA id
// master: the packer side. slave: the network TX side.
interface remote_pos_packer_if #(
   parameter int TDATA_WIDTH = 512,
   parameter int DEST_WIDTH  = 4
) ();
   logic [TDATA_WIDTH-1:0] o_tdata;
   logic                   o_tvalid;
   logic                   i_tready;
   logic                   o_tlast;
   logic [DEST_WIDTH-1:0]  o_tdest;

   modport master (output o_tdata, output o_tvalid, output o_tlast, output o_tdest,
                   input  i_tready);
   modport slave  (input  o_tdata, input  o_tvalid, input  o_tlast, input  o_tdest,
                   output i_tready);
endinterface

// File: rtl/remote_pos_packer.sv
// remote_pos_packer
// Packs {lifetime, gcid, offset packet} records into multi-slot AXI-Stream
// beats for one destination FPGA. Beats are queued in an output FIFO that
// honours backpressure. At iteration end a partial beat is flushed and a
// tlast marker beat carrying the iteration's record count is sent.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_dest_id       destination id, captured on reset release / i_iter_start
//   i_pkt, i_gcid,
//   i_lifetime,
//   i_valid/o_ready record input handshake
//   i_iter_done     level, ends the current iteration
//   i_iter_start    pulse, starts the next iteration (only honoured in DONE)
//   axis            AXI-Stream TX (master modport)
//   o_pkt_count     records accepted this iteration
//   o_done          marker beat accepted downstream
//
// Optional build macro REMOTE_POS_TIMEOUT_FLUSH_EN: pushes a partial beat
// after TIMEOUT_CYCLES consecutive cycles without an accepted record.
//
// state | meaning
// FILL  | accepting records into the staging beat
// FLUSH | pushing the partial staging beat, if any
// MARK  | pushing the tlast marker beat with the record count
// DONE  | waiting for the marker to drain and for i_iter_start
module remote_pos_packer #(
   parameter int OFFSET_PKT_WIDTH = 80,
   parameter int GCID_WIDTH       = 9,
   parameter int LIFETIME_WIDTH   = 4,
   parameter int TDATA_WIDTH      = 512,
   parameter int SLOT_WIDTH       = 128,
   parameter int FIFO_DEPTH       = 8,
   parameter int DEST_WIDTH       = 4,
   parameter int CNT_WIDTH        = 16,
   parameter int TIMEOUT_CYCLES   = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DEST_WIDTH-1:0]       i_dest_id,
   input  logic [OFFSET_PKT_WIDTH-1:0] i_pkt,
   input  logic [GCID_WIDTH-1:0]       i_gcid,
   input  logic [LIFETIME_WIDTH-1:0]   i_lifetime,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic                        i_iter_done,
   input  logic                        i_iter_start,
   remote_pos_packer_if.master         axis,
   output logic [CNT_WIDTH-1:0]        o_pkt_count,
   output logic                        o_done
);

   localparam int SLOTS = TDATA_WIDTH / SLOT_WIDTH;
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int REC_W = OFFSET_PKT_WIDTH + GCID_WIDTH + LIFETIME_WIDTH;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOTS - 1);

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_MARK  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   if (REC_W + 1 > SLOT_WIDTH) begin : g_bad_slot
      $error("remote_pos_packer: record plus valid bit does not fit in a slot");
   end
   if (TDATA_WIDTH % SLOT_WIDTH != 0) begin : g_bad_tdata
      $error("remote_pos_packer: TDATA_WIDTH must be a multiple of SLOT_WIDTH");
   end
   if (CNT_WIDTH > TDATA_WIDTH || FIFO_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_misc
      $error("remote_pos_packer: unsupported CNT_WIDTH/FIFO_DEPTH/TIMEOUT_CYCLES");
   end

   logic [1:0]             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [TDATA_WIDTH-1:0] stage_q, stage_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [DEST_WIDTH-1:0]  tdest_q, tdest_d;
   logic                   live_q;
   logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [TDATA_WIDTH:0]   mem_q [FIFO_DEPTH];

`ifdef REMOTE_POS_TIMEOUT_FLUSH_EN
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [IDLE_W-1:0] idle_q, idle_d;
`endif

   logic                   fifo_empty, fifo_full, pop, accept;
   logic                   push, push_last;
   logic [TDATA_WIDTH-1:0] push_data;
   logic [SLOT_WIDTH-1:0]  new_slot;
   logic [TDATA_WIDTH-1:0] stage_ins;
   logic [TDATA_WIDTH:0]   head;

   // Extra pointer MSB tells full from empty when the indices match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop        = !fifo_empty && axis.i_tready;

   // live_q keeps o_ready low while reset is held.
   assign o_ready = live_q && (state_q == ST_FILL) && !fifo_full;
   assign accept  = i_valid && o_ready;

   always_comb begin
      new_slot = '0;
      new_slot[REC_W-1:0]    = {i_lifetime, i_gcid, i_pkt};
      new_slot[SLOT_WIDTH-1] = 1'b1;
      stage_ins = stage_q;
      stage_ins[idx_q*SLOT_WIDTH +: SLOT_WIDTH] = new_slot;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      stage_d   = stage_q;
      cnt_d     = cnt_q;
      tdest_d   = tdest_q;
      push      = 1'b0;
      push_last = 1'b0;
      push_data = '0;
`ifdef REMOTE_POS_TIMEOUT_FLUSH_EN
      idle_d    = idle_q;
`endif

      if (!live_q) begin
         tdest_d = i_dest_id;
      end

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  push      = 1'b1;
                  push_data = stage_ins;
                  stage_d   = '0;
                  idx_d     = '0;
               end else begin
                  stage_d = stage_ins;
                  idx_d   = idx_q + 1'b1;
               end
            end
`ifdef REMOTE_POS_TIMEOUT_FLUSH_EN
            // Down-counter reloaded on every acceptance; terminal count
            // with a partial beat pending forces it out.
            if (accept) begin
               idle_d = IDLE_W'(TIMEOUT_CYCLES - 1);
            end else if (idx_q != '0) begin
               if (idle_q != '0) begin
                  idle_d = idle_q - 1'b1;
               end else if (!fifo_full) begin
                  push      = 1'b1;
                  push_data = stage_q;
                  stage_d   = '0;
                  idx_d     = '0;
               end
            end
`endif
            if (i_iter_done) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (idx_q == '0) begin
               state_d = ST_MARK;
            end else if (!fifo_full) begin
               push      = 1'b1;
               push_data = stage_q;
               stage_d   = '0;
               idx_d     = '0;
               state_d   = ST_MARK;
            end
         end
         ST_MARK: begin
            if (!fifo_full) begin
               push      = 1'b1;
               push_last = 1'b1;
               push_data = TDATA_WIDTH'(cnt_q);
               state_d   = ST_DONE;
            end
         end
         default: begin
            if (i_iter_start) begin
               cnt_d   = '0;
               idx_d   = '0;
               stage_d = '0;
               tdest_d = i_dest_id;
               state_d = ST_FILL;
            end
         end
      endcase

      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_FILL;
         idx_q    <= '0;
         stage_q  <= '0;
         cnt_q    <= '0;
         tdest_q  <= '0;
         live_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
`ifdef REMOTE_POS_TIMEOUT_FLUSH_EN
         idle_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         stage_q  <= stage_d;
         cnt_q    <= cnt_d;
         tdest_q  <= tdest_d;
         live_q   <= 1'b1;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
`ifdef REMOTE_POS_TIMEOUT_FLUSH_EN
         idle_q   <= idle_d;
`endif
      end
   end

   // Pushes only happen with space, so a write never lands on the head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= {push_last, push_data};
      end
   end

   // Head is masked when empty so the bus reads zero after reset.
   assign head          = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign axis.o_tvalid = !fifo_empty;
   assign axis.o_tdata  = head[TDATA_WIDTH-1:0];
   assign axis.o_tlast  = head[TDATA_WIDTH];
   assign axis.o_tdest  = tdest_q;
   assign o_pkt_count   = cnt_q;
   assign o_done        = (state_q == ST_DONE) && fifo_empty;

endmodule
